// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp_adder between NUM_REQ requesters.
// Optional FP_ADD_ARB_STATS_EN adds op_count and busy outputs.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] big, sml;
  logic [7:0]  eb, es, diff;
  logic [23:0] mb, ms;
  logic [49:0] wide;
  logic [26:0] x, y, n;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [22:0] frac;
  logic        rnd, found;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb   = big[30:23];
    es   = sml[30:23];
    mb   = (eb != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
    ms   = (es != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
    diff = eb - es;
    wide = {ms, 26'd0} >> diff;
    x    = {mb, 3'b000};
    // guard, round and sticky bits follow the 24-bit mantissa
    y    = {wide[49:24], |wide[23:0]};
    if (big[31] == sml[31]) sum = {1'b0, x} + {1'b0, y};
    else sum = {1'b0, x} - {1'b0, y};
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = 5'(26 - i);
      end
    end
    e = {2'b00, eb};
    if (sum[27]) begin
      n = {sum[27:2], |sum[1:0]};
      e = e + 10'd1;
    end else begin
      n = sum[26:0] << lz;
      e = e - {5'd0, lz};
    end
    rnd  = n[2] & (n[1] | n[0] | n[3]);
    frac = n[25:3] + {22'd0, rnd};
    if ((&n[26:3]) && rnd) e = e + 10'd1;
    if (sum == 28'd0) result = {big[31] & sml[31], 31'd0};
    else if (e[9] || e == 10'd0) result = {big[31], 31'd0};
    else if (e >= 10'd255) result = {big[31], 8'hFF, 23'd0};
    else result = {big[31], e[7:0], frac};
  end
endmodule

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
`ifdef FP_ADD_ARB_STATS_EN
  output logic [15:0]            op_count,
  output logic                   busy,
`endif
  input  logic                   rsp_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr, op_id, winner, cand;
  logic [31:0]     op_a, op_b, sum;
  logic            any, found;
  int              idx;

  assign any = |req_valid;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any) req_ready[winner] = 1'b1;
  end

  fp_adder u_add (
    .a      (op_a),
    .b      (op_b),
    .result (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_id      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      unique case (state)
        IDLE: if (any) begin
          op_a   <= req_a[32*winner +: 32];
          op_b   <= req_b[32*winner +: 32];
          op_id  <= winner;
          rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_result <= sum;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ADD_ARB_STATS_EN
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) op_count <= 16'd0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: table-driven ops plus fairness,
// backpressure and mid-operation reset sequences.
module tb_fp_add_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_ready;
`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0]  op_count;
  logic         busy;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[7];

  fp_add_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef FP_ADD_ARB_STATS_EN
    .op_count   (op_count),
    .busy       (busy),
`endif
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid = 4'b0001 << idx;
    rsp_ready = 1'b1;
    #1;
    chk($sformatf("grant%0d", idx), {28'd0, req_ready}, 32'(4'b0001 << idx));
`ifdef FP_ADD_ARB_STATS_EN
    chk("busy_idle", {31'd0, busy}, 32'd0);
`endif
    tick();
    req_valid = 4'b0000;
    #1;
    chk("exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready", {28'd0, req_ready}, 32'd0);
`ifdef FP_ADD_ARB_STATS_EN
    chk("busy_exec", {31'd0, busy}, 32'd1);
`endif
    tick();
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {30'd0, rsp_id}, 32'(idx));
    chk($sformatf("result%0d", idx), rsp_result, res);
`ifdef FP_ADD_ARB_STATS_EN
    chk("busy_resp", {31'd0, busy}, 32'd1);
`endif
    tick();
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{0, 32'h44000000, 32'h41B40000, 32'h4405A000};
    vecs[1] = '{2, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[2] = '{1, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[3] = '{3, 32'h3F800000, 32'hBF800000, 32'h00000000};
    vecs[4] = '{1, 32'h40400000, 32'h3F800000, 32'h40800000};
    vecs[5] = '{2, 32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[6] = '{0, 32'h3F800001, 32'h33800000, 32'h3F800002};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {28'd0, req_ready}, 32'd0);

    for (int v = 0; v < 7; v++) run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].res);

    // fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h3F800000;
      req_b[32*i +: 32] = 32'h40000000;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_grant%0d", g), {28'd0, req_ready}, 32'(4'b0001 << (g % 4)));
      tick();
      tick();
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("rr_id%0d", g), {30'd0, rsp_id}, 32'(g % 4));
      chk("rr_result", rsp_result, 32'h40400000);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    // backpressure with requester 3 waiting
    req_a[63:32] = 32'h40400000;
    req_b[63:32] = 32'h3F800000;
    req_a[127:96] = 32'h3F800000;
    req_b[127:96] = 32'h3F800000;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b1000;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_result", rsp_result, 32'h40800000);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_last", {28'd0, req_ready}, 32'd0);
    tick();
    chk("bp_done", {31'd0, rsp_valid}, 32'd0);
    chk("bp_wait_grant", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("bp_wait_id", {30'd0, rsp_id}, 32'd3);
    chk("bp_wait_result", rsp_result, 32'h40000000);
    tick();

    // reset during EXEC discards the operation and the pointer
    req_a[95:64] = 32'h3F800000;
    req_b[95:64] = 32'h40000000;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ptr", {28'd0, req_ready}, 32'h1);
    req_valid = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("mid_rst_no_rsp", {31'd0, seen}, 32'd0);

`ifdef FP_ADD_ARB_STATS_EN
    for (int k = 0; k < 3; k++) run_op(k, 32'h3F800000, 32'h40000000, 32'h40400000);
    chk("op_count3", {16'd0, op_count}, 32'd3);
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    run_op(3, 32'h3F800000, 32'h40000000, 32'h40400000);
    chk("op_count_wrap", {16'd0, op_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
